// File: rtl/mux8x1_rr_sched_pkg.sv
// mux8x1_pkg: shared sizes and FSM state type for the round-robin mux scheduler
package mux8x1_pkg;
    localparam int NREQ  = 8;
    localparam int SEL_W = 3;
    typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/mux8x1_rr_sched_if.sv
// mux8x1_rr_sched_if: request/data inputs and the granted valid/ready output channel
interface mux8x1_rr_sched_if;
    import mux8x1_pkg::*;
    logic [NREQ-1:0]  req;
    logic [NREQ-1:0]  i;
    logic             y_ready;
    logic [SEL_W-1:0] s;
    logic [NREQ-1:0]  gnt;
    logic             y;
    logic             y_valid;
    logic             busy;
    modport master (output req, i, y_ready, input s, gnt, y, y_valid, busy);
    modport slave  (input req, i, y_ready, output s, gnt, y, y_valid, busy);
endinterface

// File: rtl/mux8x1_rr_sched_pick.sv
// rr_pick8: combinational rotating-priority picker, first set request at or after ptr
module rr_pick8
    import mux8x1_pkg::*;
(
    input  logic [NREQ-1:0]  req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic             any_o,
    output logic [SEL_W-1:0] idx_o
);
    logic [2*NREQ-1:0] dbl;
    always_comb begin
        any_o = |req_i;
        dbl   = {req_i, req_i} >> ptr_i;
        idx_o = '0;
        // descending scan so the lowest rotated position wins
        for (int j = NREQ - 1; j >= 0; j--)
            if (dbl[j]) idx_o = ptr_i + SEL_W'(j);
    end
endmodule

// File: rtl/mux8x1_rr_sched.sv
// mux8x1_rr_sched: round-robin owner of an 8:1 bit-mux with a registered valid/ready output
module mux8x1_rr_sched
    import mux8x1_pkg::*;
#(
    parameter int MAX_HOLD = 4
) (
    input logic             clk,
    input logic             rst,
    mux8x1_rr_sched_if.slave bus
);
    state_t           state_q, state_d;
    logic [SEL_W-1:0] s_q, s_d, ptr_q, ptr_d, idx;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             y_q, y_d, y_valid_q, y_valid_d, any, beat, rel;

    rr_pick8 u_pick (.req_i(bus.req), .ptr_i(ptr_q), .any_o(any), .idx_o(idx));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            s_q       <= '0;
            gnt_q     <= '0;
            y_q       <= 1'b0;
            y_valid_q <= 1'b0;
            ptr_q     <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            gnt_q     <= gnt_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        gnt_d     = gnt_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        beat      = (state_q == GRANT) && bus.req[s_q] && y_valid_q && bus.y_ready;
        // a dropped request releases even when ready is high; that cycle is not a beat
        rel       = (state_q == GRANT) && (!bus.req[s_q] || (beat && cnt_q == 8'(MAX_HOLD - 1)));
        if (state_q == IDLE) begin
            if (any) begin
                state_d = GRANT;
                s_d     = idx;
                gnt_d   = NREQ'(1) << idx;
                cnt_d   = '0;
            end
        end else begin
            y_d       = bus.i[s_q];
            y_valid_d = bus.req[s_q];
            cnt_d     = cnt_q + 8'(beat);
            if (rel) begin
                state_d   = IDLE;
                gnt_d     = '0;
                y_valid_d = 1'b0;
                ptr_d     = s_q + SEL_W'(1);
            end
        end
    end

    always_comb begin
        bus.s       = s_q;
        bus.gnt     = gnt_q;
        bus.y       = y_q;
        bus.y_valid = y_valid_q;
        bus.busy    = (state_q == GRANT);
    end
endmodule
